// File: rtl/uart_baud_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_ctrl
// Description : Baud timing for one TX and one RX UART channel from a shared,
//               host-programmed bit divisor; RX start qualification/sampling.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_ctrl #(
  parameter int DIV_W       = 32,
  parameter int DEFAULT_DIV = 100,
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 1
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             cfg_we,
  input  logic [DIV_W-1:0] cfg_divisor,
  output logic             cfg_busy,
  output logic             cfg_rej,
  input  logic             tx_req,
  output logic             tx_ack,
  output logic             tx_tick,
  output logic             tx_done,
  input  logic             rx,
  output logic             rx_sample,
  output logic             rx_bit,
  output logic [3:0]       rx_bit_idx,
  output logic             rx_done,
  output logic             rx_frame_err
);

  localparam int c_FRAME_LEN = 1 + DATA_BITS + STOP_BITS;
  localparam int c_NB_W      = $clog2(c_FRAME_LEN + 1);

  typedef enum logic [0:0] {TX_IDLE, TX_RUN} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic [DIV_W-1:0]  r_div;
  logic              r_cfg_rej;

  tx_state_t         r_tx_state, w_tx_state_nx;
  logic [DIV_W-1:0]  r_tx_cnt, w_tx_cnt_nx;
  logic [DIV_W-1:0]  r_tx_div, w_tx_div_nx;
  logic [c_NB_W-1:0] r_tx_nbits, w_tx_nbits_nx;
  logic              w_tx_ack, w_tx_tick, w_tx_done;

  logic              r_rx_meta, r_rx_s, r_rx_prev;
  rx_state_t         r_rx_state, w_rx_state_nx;
  logic [DIV_W-1:0]  r_rx_cnt, w_rx_cnt_nx;
  logic [DIV_W-1:0]  r_rx_div, w_rx_div_nx;
  logic [3:0]        r_rx_idx, w_rx_idx_nx;
  logic              w_rx_sample, w_rx_done, w_rx_err;

  logic              w_rx_start;
  logic              w_cfg_ok;
  logic [DIV_W-1:0]  w_rx_half;

  assign cfg_busy   = (r_tx_state != TX_IDLE) | (r_rx_state != RX_IDLE);
  assign w_rx_start = (r_rx_state == RX_IDLE) & r_rx_prev & ~r_rx_s;
  // A pending TX request or a just-seen RX start would latch the old divisor
  // this same cycle, so both block a reconfiguration.
  assign w_cfg_ok   = cfg_we & ~cfg_busy & ~tx_req & ~w_rx_start;
  assign w_rx_half  = r_rx_div >> 1;

  always_ff @(posedge clk) begin
    if (areset) begin
      r_div     <= DIV_W'(DEFAULT_DIV);
      r_cfg_rej <= 1'b0;
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      if (w_cfg_ok) r_div <= (cfg_divisor < DIV_W'(2)) ? DIV_W'(2) : cfg_divisor;
      r_cfg_rej <= cfg_we & ~w_cfg_ok;
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;
    end
  end

  // TX channel
  always_ff @(posedge clk) begin
    if (areset) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_div   <= '0;
      r_tx_nbits <= '0;
    end else begin
      r_tx_state <= w_tx_state_nx;
      r_tx_cnt   <= w_tx_cnt_nx;
      r_tx_div   <= w_tx_div_nx;
      r_tx_nbits <= w_tx_nbits_nx;
    end
  end

  always_comb begin
    w_tx_state_nx = r_tx_state;
    w_tx_cnt_nx   = r_tx_cnt;
    w_tx_div_nx   = r_tx_div;
    w_tx_nbits_nx = r_tx_nbits;
    w_tx_ack      = 1'b0;
    w_tx_tick     = 1'b0;
    w_tx_done     = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        if (tx_req) begin
          w_tx_ack      = 1'b1;
          w_tx_state_nx = TX_RUN;
          w_tx_cnt_nx   = '0;
          w_tx_div_nx   = r_div;
          w_tx_nbits_nx = c_NB_W'(c_FRAME_LEN);
        end
      end
      TX_RUN: begin
        if (r_tx_cnt == r_tx_div - 1'b1) begin
          w_tx_tick     = 1'b1;
          w_tx_cnt_nx   = '0;
          w_tx_nbits_nx = r_tx_nbits - 1'b1;
          if (r_tx_nbits == c_NB_W'(1)) begin
            w_tx_done     = 1'b1;
            w_tx_state_nx = TX_IDLE;
          end
        end else begin
          w_tx_cnt_nx = r_tx_cnt + 1'b1;
        end
      end
      default: w_tx_state_nx = TX_IDLE;
    endcase
  end

  // RX channel
  always_ff @(posedge clk) begin
    if (areset) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_div   <= '0;
      r_rx_idx   <= '0;
    end else begin
      r_rx_state <= w_rx_state_nx;
      r_rx_cnt   <= w_rx_cnt_nx;
      r_rx_div   <= w_rx_div_nx;
      r_rx_idx   <= w_rx_idx_nx;
    end
  end

  always_comb begin
    w_rx_state_nx = r_rx_state;
    w_rx_cnt_nx   = r_rx_cnt;
    w_rx_div_nx   = r_rx_div;
    w_rx_idx_nx   = r_rx_idx;
    w_rx_sample   = 1'b0;
    w_rx_done     = 1'b0;
    w_rx_err      = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (w_rx_start) begin
          w_rx_state_nx = RX_START;
          w_rx_cnt_nx   = '0;
          w_rx_div_nx   = r_div;
        end
      end
      RX_START: begin
        // Line must still be low half a bit after the edge, else it was a glitch.
        if (r_rx_cnt == w_rx_half - 1'b1) begin
          w_rx_cnt_nx = '0;
          if (!r_rx_s) begin
            w_rx_state_nx = RX_DATA;
            w_rx_idx_nx   = '0;
          end else begin
            w_rx_state_nx = RX_IDLE;
          end
        end else begin
          w_rx_cnt_nx = r_rx_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (r_rx_cnt == r_rx_div - 1'b1) begin
          w_rx_sample = 1'b1;
          w_rx_cnt_nx = '0;
          w_rx_idx_nx = r_rx_idx + 1'b1;
          if (r_rx_idx == 4'(DATA_BITS - 1)) w_rx_state_nx = RX_STOP;
        end else begin
          w_rx_cnt_nx = r_rx_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (r_rx_cnt == r_rx_div - 1'b1) begin
          w_rx_done     = 1'b1;
          w_rx_err      = ~r_rx_s;
          w_rx_cnt_nx   = '0;
          w_rx_state_nx = RX_IDLE;
        end else begin
          w_rx_cnt_nx = r_rx_cnt + 1'b1;
        end
      end
      default: w_rx_state_nx = RX_IDLE;
    endcase
  end

  // Strobes are suppressed during reset so an aborted frame never signals completion.
  assign cfg_rej      = r_cfg_rej;
  assign tx_ack       = w_tx_ack & ~areset;
  assign tx_tick      = w_tx_tick & ~areset;
  assign tx_done      = w_tx_done & ~areset;
  assign rx_sample    = w_rx_sample & ~areset;
  assign rx_bit       = rx_sample & r_rx_s;
  assign rx_bit_idx   = rx_sample ? r_rx_idx : 4'd0;
  assign rx_done      = w_rx_done & ~areset;
  assign rx_frame_err = w_rx_err & ~areset;

endmodule
`default_nettype wire

// File: tb/tb_uart_baud_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_baud_ctrl
// Description : Directed self-checking bench for uart_baud_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_baud_ctrl;

  logic        clk = 1'b0;
  logic        areset, cfg_we, tx_req, rx;
  logic [31:0] cfg_divisor;
  logic        cfg_busy, cfg_rej, tx_ack, tx_tick, tx_done;
  logic        rx_sample, rx_bit, rx_done, rx_frame_err;
  logic [3:0]  rx_bit_idx;

  always #5 clk = ~clk;

  uart_baud_ctrl dut (
    .clk(clk), .areset(areset), .cfg_we(cfg_we), .cfg_divisor(cfg_divisor),
    .cfg_busy(cfg_busy), .cfg_rej(cfg_rej), .tx_req(tx_req), .tx_ack(tx_ack),
    .tx_tick(tx_tick), .tx_done(tx_done), .rx(rx), .rx_sample(rx_sample),
    .rx_bit(rx_bit), .rx_bit_idx(rx_bit_idx), .rx_done(rx_done),
    .rx_frame_err(rx_frame_err)
  );

  int passes = 0, fails = 0, total = 0;

  int ack_n, ack_first, ack_last, tick_n, tick_first, done_n, done_cyc;
  int rej_n, rej_cyc, samp_n, samp_first, idx_bad, rxd_n, rxd_cyc, rst_nz;
  logic [15:0] samp_bits;
  logic        rxd_err, busy_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #2;
  endtask

  // One directed scenario of ncyc cycles; cycle 0 is the first cycle after the call.
  task automatic run(input int ncyc, input int tx_start, input bit tx_hold,
                     input int rx_start, input int rx_glitch, input logic [7:0] rx_data,
                     input logic rx_stop, input int rx_div, input int cfg_at,
                     input logic [31:0] cfg_val, input int rst_at);
    bit tx_pend = 1'b0;
    int bn;
    ack_n = 0; ack_first = -1; ack_last = -1; tick_n = 0; tick_first = -1;
    done_n = 0; done_cyc = -1; rej_n = 0; rej_cyc = -1; samp_n = 0;
    samp_first = -1; idx_bad = 0; rxd_n = 0; rxd_cyc = -1; rst_nz = 0;
    samp_bits = '0; rxd_err = 1'bx; busy_last = 1'bx;
    for (int c = 0; c < ncyc; c++) begin
      next();
      if (c == tx_start) tx_pend = 1'b1;
      tx_req      = tx_pend;
      cfg_we      = (c == cfg_at);
      cfg_divisor = cfg_val;
      areset      = (c == rst_at);
      if (rx_start < 0 || c < rx_start || (rst_at >= 0 && c >= rst_at)) rx = 1'b1;
      else if (rx_glitch > 0) rx = ((c - rx_start) >= rx_glitch);
      else begin
        bn = (c - rx_start) / rx_div;
        if (bn == 0)      rx = 1'b0;
        else if (bn <= 8) rx = rx_data[bn-1];
        else if (bn == 9) rx = rx_stop;
        else              rx = 1'b1;
      end
      #1;
      if (tx_ack) begin
        if (ack_n == 0) ack_first = c;
        ack_last = c;
        ack_n++;
        if (!tx_hold) tx_pend = 1'b0;
      end
      if (tx_tick) begin
        if (tick_n == 0) tick_first = c;
        tick_n++;
      end
      if (tx_done) begin done_n++; done_cyc = c; end
      if (cfg_rej) begin rej_n++; rej_cyc = c; end
      if (rx_sample) begin
        if (int'(rx_bit_idx) != samp_n) idx_bad++;
        samp_bits[rx_bit_idx] = rx_bit;
        if (samp_n == 0) samp_first = c;
        samp_n++;
      end
      if (rx_done) begin rxd_n++; rxd_cyc = c; rxd_err = rx_frame_err; end
      if (rst_at >= 0 && c == rst_at + 1)
        rst_nz = int'(|{cfg_busy, cfg_rej, tx_ack, tx_tick, tx_done, rx_sample,
                        rx_bit, rx_bit_idx, rx_done, rx_frame_err});
      busy_last = cfg_busy;
    end
    tx_req = 1'b0; cfg_we = 1'b0; areset = 1'b0; rx = 1'b1;
  endtask

  initial begin
    areset = 1'b1; cfg_we = 1'b0; tx_req = 1'b0; rx = 1'b1; cfg_divisor = '0;
    repeat (3) next();
    areset = 1'b0;
    next();
    #1;
    check("reset_outputs", 32'({cfg_busy, cfg_rej, tx_ack, tx_tick, tx_done, rx_sample,
                                rx_bit, rx_bit_idx, rx_done, rx_frame_err}), 32'd0);

    // Default divisor 100, tx_req held through the end of the frame.
    run(1002, 0, 1'b1, -1, 0, 8'h00, 1'b1, 8, -1, 0, -1);
    check("t1_ack_first", ack_first, 0);
    check("t1_tick_first", tick_first, 100);
    check("t1_tick_n", tick_n, 10);
    check("t1_done_n", done_n, 1);
    check("t1_done_cyc", done_cyc, 1000);
    check("t1_reack_cyc", ack_last, 1001);
    check("t1_ack_n", ack_n, 2);

    // Program divisor 8 while idle.
    run(3, -1, 1'b0, -1, 0, 8'h00, 1'b1, 8, 0, 32'd8, -1);
    check("t2_cfg_rej_n", rej_n, 0);
    run(90, 0, 1'b0, -1, 0, 8'h00, 1'b1, 8, -1, 0, -1);
    check("t2_tx_tick_first", tick_first, 8);
    check("t2_tx_done_cyc", done_cyc, 80);
    run(100, -1, 1'b0, 0, 0, 8'h55, 1'b1, 8, -1, 0, -1);
    check("t2_samp_n", samp_n, 8);
    check("t2_samp_bits", 32'(samp_bits), 32'h55);
    check("t2_idx_bad", idx_bad, 0);
    check("t2_samp_first", samp_first, 14);
    check("t2_rxd_n", rxd_n, 1);
    check("t2_rxd_cyc", rxd_cyc, 78);
    check("t2_frame_err", 32'(rxd_err), 32'd0);

    // Reconfiguration refused while TX runs; running frame keeps its divisor.
    run(90, 0, 1'b0, -1, 0, 8'h00, 1'b1, 8, 5, 32'd20, -1);
    check("t3_rej_n", rej_n, 1);
    check("t3_rej_cyc", rej_cyc, 6);
    check("t3_done_cyc", done_cyc, 80);
    run(90, 0, 1'b0, -1, 0, 8'h00, 1'b1, 8, -1, 0, -1);
    check("t3_div_kept", done_cyc, 80);
    run(3, -1, 1'b0, -1, 0, 8'h00, 1'b1, 8, 0, 32'd1, -1);
    check("t3_min_rej_n", rej_n, 0);
    run(30, 0, 1'b0, -1, 0, 8'h00, 1'b1, 8, -1, 0, -1);
    check("t3_min_tick_first", tick_first, 2);
    check("t3_min_done_cyc", done_cyc, 20);
    run(3, -1, 1'b0, -1, 0, 8'h00, 1'b1, 8, 0, 32'd8, -1);

    // Short glitch is rejected; stop bit held low reports a framing error.
    run(40, -1, 1'b0, 0, 2, 8'h00, 1'b1, 8, -1, 0, -1);
    check("t4_glitch_samp_n", samp_n, 0);
    check("t4_glitch_rxd_n", rxd_n, 0);
    check("t4_glitch_idle", 32'(busy_last), 32'd0);
    run(100, -1, 1'b0, 0, 0, 8'hA6, 1'b0, 8, -1, 0, -1);
    check("t4_ferr_bits", 32'(samp_bits), 32'hA6);
    check("t4_ferr_rxd_cyc", rxd_cyc, 78);
    check("t4_ferr_flag", 32'(rxd_err), 32'd1);

    // Same-cycle tx_req and cfg_we; then overlapping TX and RX frames.
    run(90, 0, 1'b0, -1, 0, 8'h00, 1'b1, 8, 0, 32'd3, -1);
    check("t5_ack_first", ack_first, 0);
    check("t5_rej_cyc", rej_cyc, 1);
    check("t5_done_cyc", done_cyc, 80);
    run(100, 0, 1'b0, 5, 0, 8'h3C, 1'b1, 8, -1, 0, -1);
    check("t5_ovl_tx_done", done_cyc, 80);
    check("t5_ovl_tick_n", tick_n, 10);
    check("t5_ovl_samp_first", samp_first, 19);
    check("t5_ovl_bits", 32'(samp_bits), 32'h3C);
    check("t5_ovl_rxd_cyc", rxd_cyc, 83);
    check("t5_ovl_err", 32'(rxd_err), 32'd0);

    // Reset during data bit 3 aborts the frame; divisor returns to 100.
    run(60, -1, 1'b0, 0, 0, 8'h55, 1'b1, 8, -1, 0, 36);
    check("t6_samp_before_rst", samp_n, 3);
    check("t6_no_rxd", rxd_n, 0);
    check("t6_outputs_zero", rst_nz, 0);
    check("t6_idle", 32'(busy_last), 32'd0);
    run(1100, -1, 1'b0, 0, 0, 8'hC9, 1'b1, 100, -1, 0, -1);
    check("t6_fresh_samp_first", samp_first, 152);
    check("t6_fresh_bits", 32'(samp_bits), 32'hC9);
    check("t6_fresh_rxd_cyc", rxd_cyc, 952);
    check("t6_fresh_err", 32'(rxd_err), 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
`default_nettype wire
